// File: rtl/sram_tlul_host_arb.sv
// sram_tlul_host_arb
//   Shares one TL-UL host port among NumReq SRAM-style requesters.
//   - Round-robin arbitration. The search starts at the rr pointer, and the
//     pointer moves to winner+1 after each grant.
//   - The A channel is registered. A grant loads the A register and the FSM
//     moves to SEND. The FSM holds a_valid until a_ready, so at most one beat
//     is issued every 2 cycles.
//   - A limit on outstanding transactions: no grant while outst_cnt == MaxOutst.
//   - The D channel is routed combinationally to requester d_source. A response
//     that arrives while outst_cnt == 0 is dropped.
// Ports
//   clk_i, rst_i                 clock, async active-high reset
//   req_i/write_i/addr_i/wdata_i per-requester SRAM requests (packed by requester)
//   gnt_o                        one-hot, request captured this cycle
//   rvalid_o/rdata_o/rerror_o    one-hot response strobe plus data/error
//   tl_a_*                       TL-UL A channel (size fixed 2, mask fixed 4'hF)
//   tl_d_*                       TL-UL D channel, tl_d_ready_o tied to 1
//   dbg_state_o/dbg_outst_o/dbg_rr_o  FSM state, outstanding count, rr pointer
// Handshake: an A beat transfers on a cycle where tl_a_valid_o && tl_a_ready_i
//   are both high. While tl_a_valid_o is high, no A field changes. A D beat is
//   consumed on any cycle where tl_d_valid_i is high.
module sram_tlul_host_arb #(
  parameter int          NumReq     = 3,
  parameter int          SramAw     = 12,
  parameter int          SramDw     = 32,
  parameter logic [31:0] TlBaseAddr = 32'h0,
  parameter int          MaxOutst   = 2,
  localparam int         IdxW       = $clog2(NumReq)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumReq-1:0]        req_i,
  input  logic [NumReq-1:0]        write_i,
  input  logic [NumReq*SramAw-1:0] addr_i,
  input  logic [NumReq*SramDw-1:0] wdata_i,
  output logic [NumReq-1:0]        gnt_o,
  output logic [NumReq-1:0]        rvalid_o,
  output logic [31:0]              rdata_o,
  output logic                     rerror_o,
  output logic                     tl_a_valid_o,
  output logic [2:0]               tl_a_opcode_o,
  output logic [31:0]              tl_a_address_o,
  output logic [31:0]              tl_a_data_o,
  output logic [3:0]               tl_a_mask_o,
  output logic [7:0]               tl_a_source_o,
  input  logic                     tl_a_ready_i,
  input  logic                     tl_d_valid_i,
  input  logic [2:0]               tl_d_opcode_i,
  input  logic [31:0]              tl_d_data_i,
  input  logic [7:0]               tl_d_source_i,
  input  logic                     tl_d_error_i,
  output logic                     tl_d_ready_o,
  output logic                     dbg_state_o,
  output logic [2:0]               dbg_outst_o,
  output logic [IdxW-1:0]          dbg_rr_o
);

  typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [IdxW-1:0]   r_rr;
  logic [2:0]        r_outst;
  logic [2:0]        r_a_opcode;
  logic [31:0]       r_a_addr;
  logic [31:0]       r_a_data;
  logic [7:0]        r_a_source;

  logic              w_found;
  logic [IdxW-1:0]   w_win;
  logic [IdxW-1:0]   w_rr_nxt;
  logic              w_load;
  logic              w_accept;
  logic              w_dec;
  logic              w_rsp_ok;
  logic [NumReq-1:0] w_gnt;
  logic [NumReq-1:0] w_rvalid;
  logic [SramAw-1:0] w_win_addr;
  logic [SramDw-1:0] w_win_wdata;

  // Index (base + off) mod NumReq. The value of off is always below NumReq.
  function automatic logic [IdxW-1:0] rr_idx(input logic [IdxW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NumReq) s = s - NumReq;
    return IdxW'(s);
  endfunction

  // Round-robin search. The first requester found from r_rr upward wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (!w_found && req_i[rr_idx(r_rr, i)]) begin
        w_found = 1'b1;
        w_win   = rr_idx(r_rr, i);
      end
    end
  end

  assign w_rr_nxt    = (w_win == IdxW'(NumReq - 1)) ? '0 : w_win + 1'b1;
  assign w_win_addr  = addr_i[int'(w_win)*SramAw +: SramAw];
  assign w_win_wdata = wdata_i[int'(w_win)*SramDw +: SramDw];

  // FSM next state and grant/accept strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = '0;
    w_load      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found && (r_outst < 3'(MaxOutst))) begin
          w_gnt[w_win] = 1'b1;
          w_load       = 1'b1;
          w_state_nxt  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tl_a_ready_i) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // A register and rr pointer update only on a grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_a_opcode <= 3'd0;
      r_a_addr   <= 32'h0;
      r_a_data   <= 32'h0;
      r_a_source <= 8'h0;
      r_rr       <= '0;
    end else if (w_load) begin
      r_a_opcode <= write_i[w_win] ? 3'd0 : 3'd4;
      r_a_addr   <= TlBaseAddr | {{(30-SramAw){1'b0}}, w_win_addr, 2'b00};
      r_a_data   <= write_i[w_win] ? w_win_wdata : 32'h0;
      r_a_source <= 8'(w_win);
      r_rr       <= w_rr_nxt;
    end
  end

  // A D beat only counts while something is outstanding. This drops stray
  // responses and keeps the counter from going below zero. A stray source
  // index (>= NumReq) still retires a beat but raises no rvalid.
  assign w_dec    = tl_d_valid_i && (r_outst != 3'd0);
  assign w_rsp_ok = w_dec && (tl_d_source_i < 8'(NumReq));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_outst <= 3'd0;
    end else begin
      case ({w_accept, w_dec})
        2'b10:   r_outst <= r_outst + 3'd1;
        2'b01:   r_outst <= r_outst - 3'd1;
        default: r_outst <= r_outst;
      endcase
    end
  end

  always_comb begin
    w_rvalid = '0;
    if (w_rsp_ok) w_rvalid[tl_d_source_i[IdxW-1:0]] = 1'b1;
  end

  assign gnt_o          = w_gnt;
  assign rvalid_o       = w_rvalid;
  assign rdata_o        = (w_rsp_ok && (tl_d_opcode_i == 3'd1)) ? tl_d_data_i : 32'h0;
  assign rerror_o       = w_rsp_ok && tl_d_error_i;
  assign tl_a_valid_o   = (r_state == ST_SEND);
  assign tl_a_opcode_o  = r_a_opcode;
  assign tl_a_address_o = r_a_addr;
  assign tl_a_data_o    = r_a_data;
  assign tl_a_mask_o    = 4'hF;
  assign tl_a_source_o  = r_a_source;
  assign tl_d_ready_o   = 1'b1;
  assign dbg_state_o    = r_state;
  assign dbg_outst_o    = r_outst;
  assign dbg_rr_o       = r_rr;

endmodule

// File: tb/tb_sram_tlul_host_arb.sv
module tb_sram_tlul_host_arb;

  localparam int NumReq = 3;
  localparam int Aw     = 12;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NumReq-1:0]    req, wr;
  logic [NumReq*Aw-1:0] addr;
  logic [NumReq*32-1:0] wdata;
  logic [NumReq-1:0]    gnt, rvalid;
  logic [31:0]          rdata;
  logic                 rerror;
  logic                 a_valid;
  logic [2:0]           a_opcode;
  logic [31:0]          a_address, a_data;
  logic [3:0]           a_mask;
  logic [7:0]           a_source;
  logic                 a_ready;
  logic                 d_valid;
  logic [2:0]           d_opcode;
  logic [31:0]          d_data;
  logic [7:0]           d_source;
  logic                 d_error;
  logic                 d_ready;
  logic                 dbg_state;
  logic [2:0]           dbg_outst;
  logic [1:0]           dbg_rr;

  sram_tlul_host_arb #(
    .NumReq(NumReq), .SramAw(Aw), .SramDw(32), .TlBaseAddr(32'h0), .MaxOutst(2)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_i(req), .write_i(wr), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .rerror_o(rerror),
    .tl_a_valid_o(a_valid), .tl_a_opcode_o(a_opcode), .tl_a_address_o(a_address),
    .tl_a_data_o(a_data), .tl_a_mask_o(a_mask), .tl_a_source_o(a_source),
    .tl_a_ready_i(a_ready),
    .tl_d_valid_i(d_valid), .tl_d_opcode_i(d_opcode), .tl_d_data_i(d_data),
    .tl_d_source_i(d_source), .tl_d_error_i(d_error), .tl_d_ready_o(d_ready),
    .dbg_state_o(dbg_state), .dbg_outst_o(dbg_outst), .dbg_rr_o(dbg_rr)
  );

  // scoreboard
  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] exp_q[$];   // expected gnt one-hot, in grant order
  int          src_q[$];   // expected a_source of granted beats
  logic [31:0] rsp_q[$];   // expected rvalid one-hot of driven D beats

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req = '0; wr = '0; addr = '0; wdata = '0; a_ready = 1'b1;
    d_valid = 1'b0; d_opcode = 3'd0; d_data = 32'h0; d_source = 8'h0; d_error = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drive_d(input logic [7:0] src, input logic [2:0] opc,
                         input logic [31:0] data, input logic err);
    d_valid = 1'b1; d_source = src; d_opcode = opc; d_data = data; d_error = err;
  endtask

  int  grants;
  logic pend_d;
  int  pend_src;
  int  e;

  initial begin
    clear_inputs();
    rst = 1'b1;

    // reset state
    sample();
    chk("rst_a_valid", 32'(a_valid), 32'd0);
    chk("rst_d_ready", 32'(d_ready), 32'd1);
    chk("rst_mask", 32'(a_mask), 32'hF);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_outst", 32'(dbg_outst), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_rr", 32'(dbg_rr), 32'd0);
    chk("rst_address", a_address, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // single read
    next_cycle();
    req = 3'b001; wr = 3'b000; addr[0 +: Aw] = 12'h010; a_ready = 1'b1;
    sample();
    chk("rd_gnt", 32'(gnt), 32'b001);
    next_cycle();
    req = 3'b000;
    sample();
    chk("rd_a_valid", 32'(a_valid), 32'd1);
    chk("rd_opcode", 32'(a_opcode), 32'd4);
    chk("rd_address", a_address, 32'h40);
    chk("rd_source", 32'(a_source), 32'd0);
    chk("rd_data", a_data, 32'h0);
    next_cycle();
    drive_d(8'd0, 3'd1, 32'hDEADBEEF, 1'b0);
    exp_q.push_back(32'hDEADBEEF);
    sample();
    chk("rd_rvalid", 32'(rvalid), 32'b001);
    if (rvalid != 0 && exp_q.size() > 0) chk("rd_rdata", rdata, exp_q.pop_front());
    chk("rd_outst1", 32'(dbg_outst), 32'd1);
    next_cycle();
    d_valid = 1'b0;
    sample();
    chk("rd_outst0", 32'(dbg_outst), 32'd0);
    chk("rd_rvalid_idle", 32'(rvalid), 32'd0);

    // round-robin with immediate AccessAck (data must read as 0)
    do_reset();
    exp_q.delete();
    for (int k = 0; k < 6; k++) exp_q.push_back(32'd1 << (k % NumReq));
    for (int k = 0; k < NumReq; k++) addr[k*Aw +: Aw] = 12'(12'h100 + k);
    grants = 0; pend_d = 1'b0; pend_src = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      next_cycle();
      req = (grants < 6) ? 3'b111 : 3'b000;
      d_valid = pend_d; d_source = 8'(pend_src); d_opcode = 3'd0; d_data = 32'hFFFF_FFFF;
      if (pend_d) rsp_q.push_back(32'd1 << pend_src);
      pend_d = 1'b0;
      sample();
      if (d_valid) begin
        chk("rr_rvalid", 32'(rvalid), rsp_q.pop_front());
        chk("rr_rdata_ack", rdata, 32'h0);
      end
      if (gnt != 0) begin
        if (exp_q.size() == 0) chk("rr_extra_gnt", 32'(gnt), 32'd0);
        else begin
          for (int k = 0; k < NumReq; k++) if (exp_q[0] == (32'd1 << k)) src_q.push_back(k);
          chk("rr_gnt", 32'(gnt), exp_q.pop_front());
          grants++;
        end
      end
      if (a_valid && a_ready && src_q.size() > 0) begin
        pend_src = src_q.pop_front();
        chk("rr_a_source", 32'(a_source), 32'(pend_src));
        chk("rr_a_addr", a_address, 32'((12'h100 + pend_src) << 2));
        pend_d = 1'b1;
      end
      if (grants == 6 && !pend_d && src_q.size() == 0 && !d_valid) break;
    end
    chk("rr_grant_count", 32'(grants), 32'd6);
    chk("rr_outst_end", 32'(dbg_outst), 32'd0);
    d_valid = 1'b0;

    // backpressure
    do_reset();
    next_cycle();
    req = 3'b010; wr = 3'b010; addr[1*Aw +: Aw] = 12'h3FF; wdata[32 +: 32] = 32'hA5A5_0001;
    addr[0 +: Aw] = 12'h005; a_ready = 1'b0;
    sample();
    chk("bp_gnt", 32'(gnt), 32'b010);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      req = 3'b001;
      sample();
      chk("bp_a_valid", 32'(a_valid), 32'd1);
      chk("bp_opcode", 32'(a_opcode), 32'd0);
      chk("bp_address", a_address, 32'hFFC);
      chk("bp_data", a_data, 32'hA5A5_0001);
      chk("bp_source", 32'(a_source), 32'd1);
      chk("bp_no_gnt", 32'(gnt), 32'd0);
      chk("bp_outst", 32'(dbg_outst), 32'd0);
    end
    next_cycle();
    a_ready = 1'b1;
    sample();
    chk("bp_accept_valid", 32'(a_valid), 32'd1);
    next_cycle();
    sample();
    chk("bp_gnt2", 32'(gnt), 32'b001);
    chk("bp_outst1", 32'(dbg_outst), 32'd1);
    next_cycle();
    req = 3'b000;
    sample();
    chk("bp_get_opcode", 32'(a_opcode), 32'd4);
    chk("bp_get_address", a_address, 32'h14);
    chk("bp_get_data", a_data, 32'h0);
    next_cycle();
    drive_d(8'd1, 3'd0, 32'h1234_5678, 1'b1);
    sample();
    chk("bp_outst2", 32'(dbg_outst), 32'd2);
    chk("bp_wr_rvalid", 32'(rvalid), 32'b010);
    chk("bp_wr_rdata", rdata, 32'h0);
    chk("bp_wr_rerror", 32'(rerror), 32'd1);
    next_cycle();
    drive_d(8'd0, 3'd1, 32'hCAFE_0005, 1'b0);
    sample();
    chk("bp_rd_rvalid", 32'(rvalid), 32'b001);
    chk("bp_rd_rdata", rdata, 32'hCAFE_0005);
    next_cycle();
    d_valid = 1'b0;
    sample();
    chk("bp_outst_end", 32'(dbg_outst), 32'd0);

    // outstanding limit
    do_reset();
    for (int g = 0; g < 2; g++) begin
      next_cycle();
      req = 3'b001; wr = 3'b000;
      sample();
      chk("ol_gnt", 32'(gnt), 32'b001);
      next_cycle();
      sample();
      chk("ol_a_valid", 32'(a_valid), 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      sample();
      chk("ol_blocked_gnt", 32'(gnt), 32'd0);
      chk("ol_outst_max", 32'(dbg_outst), 32'd2);
    end
    next_cycle();
    drive_d(8'd0, 3'd1, 32'h1111_1111, 1'b0);
    sample();
    chk("ol_rvalid", 32'(rvalid), 32'b001);
    chk("ol_same_cycle_gnt", 32'(gnt), 32'd0);
    next_cycle();
    d_valid = 1'b0;
    sample();
    chk("ol_resume_gnt", 32'(gnt), 32'b001);
    chk("ol_outst1", 32'(dbg_outst), 32'd1);
    next_cycle();
    req = 3'b000;
    sample();
    chk("ol_a_valid3", 32'(a_valid), 32'd1);
    next_cycle();
    sample();
    chk("ol_outst2", 32'(dbg_outst), 32'd2);

    // error / stray responses
    next_cycle();
    drive_d(8'd5, 3'd1, 32'h5555_5555, 1'b1);
    sample();
    chk("st_src5_rvalid", 32'(rvalid), 32'd0);
    chk("st_src5_rerror", 32'(rerror), 32'd0);
    next_cycle();
    drive_d(8'd0, 3'd1, 32'h2222_2222, 1'b0);
    sample();
    chk("st_outst_after_src5", 32'(dbg_outst), 32'd1);
    chk("st_rvalid0", 32'(rvalid), 32'b001);
    next_cycle();
    d_valid = 1'b0;
    sample();
    chk("st_outst0", 32'(dbg_outst), 32'd0);
    next_cycle();
    drive_d(8'd0, 3'd1, 32'h3333_3333, 1'b0);
    sample();
    chk("st_zero_rvalid", 32'(rvalid), 32'd0);
    chk("st_zero_rdata", rdata, 32'h0);
    next_cycle();
    d_valid = 1'b0;
    sample();
    chk("st_zero_outst", 32'(dbg_outst), 32'd0);

    // reset while in SEND
    next_cycle();
    req = 3'b100; a_ready = 1'b0;
    sample();
    chk("rs_gnt", 32'(gnt), 32'b100);
    next_cycle();
    req = 3'b000;
    sample();
    chk("rs_a_valid_pre", 32'(a_valid), 32'd1);
    chk("rs_rr_pre", 32'(dbg_rr), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("rs_a_valid_async", 32'(a_valid), 32'd0);
    chk("rs_state", 32'(dbg_state), 32'd0);
    chk("rs_rr", 32'(dbg_rr), 32'd0);
    chk("rs_outst", 32'(dbg_outst), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive_d(8'd2, 3'd1, 32'h4444_4444, 1'b0);
    sample();
    chk("rs_drop_rvalid", 32'(rvalid), 32'd0);
    next_cycle();
    d_valid = 1'b0;
    sample();
    chk("rs_drop_outst", 32'(dbg_outst), 32'd0);

    e = n_err;
    $display("Result: errors=%0d of %0d checks", e, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
